// File: rtl/xor_parity_scheduler_if.sv
// Request/response bundle between client logic and xor_parity_scheduler.
//   reqValid/reqData/reqOdd : per-requester work offer (word i at [i*DATA_WIDTH +: DATA_WIDTH])
//   reqReady                : one-hot accept strobe back to the requesters
//   respValid/respId/respParity, respReady : single result channel with backpressure
// master = client side, slave = scheduler side.
interface xor_parity_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            reqValid;
  logic [NUM_REQ*DATA_WIDTH-1:0] reqData;
  logic [NUM_REQ-1:0]            reqOdd;
  logic [NUM_REQ-1:0]            reqReady;
  logic                          respValid;
  logic                          respReady;
  logic [ID_W-1:0]               respId;
  logic                          respParity;

  modport master (
    output reqValid, reqData, reqOdd, respReady,
    input  reqReady, respValid, respId, respParity
  );

  modport slave (
    input  reqValid, reqData, reqOdd, respReady,
    output reqReady, respValid, respId, respParity
  );
endinterface

// File: rtl/xor_parity_scheduler.sv
// xor_parity_scheduler: time-shares one CHUNK_WIDTH-wide _xor reduction between
// NUM_REQ requesters. A granted word is walked chunk by chunk through _xor, the
// chunk results are accumulated and the word parity is returned with the requester ID.
// Ports:
//   clock       : rising-edge clock
//   resetN      : synchronous active-low reset
//   DigitSupply : supply pair, passed straight to the _xor instance
//   bus         : request/response bundle (slave side)
//   busy        : high whenever the FSM is not IDLE

// Combinational XOR reduction of one chunk.
module _xor #(
  parameter int INPUT_WIDTH = 8
) (
  input  logic [1:0]             DigitSupply,
  input  logic [INPUT_WIDTH-1:0] xorIn,
  output logic                   xorOut
);
  // Supply pins carry no logic function in this model.
  logic unusedSupply;
  assign unusedSupply = ^DigitSupply;
  assign xorOut       = ^xorIn;
endmodule

module xor_parity_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic [1:0]           DigitSupply,
  xor_parity_scheduler_if.slave bus,
  output logic                 busy
);
  localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [ID_W-1:0]    LAST_ID    = ID_W'(NUM_REQ - 1);
  localparam logic [CIDX_W-1:0]  LAST_CHUNK = CIDX_W'(NCHUNK - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, RUN, RESP} stateT;

  stateT                 state, stateNext;
  logic [ID_W-1:0]       rrPtr;
  logic [CIDX_W-1:0]     chunkIdx;
  logic                  acc;
  logic [DATA_WIDTH-1:0] dataReg;
  logic [ID_W-1:0]       idReg;
  logic                  oddReg;
  logic [ID_W-1:0]       respIdReg;
  logic                  respParityReg;

  logic [ID_W-1:0]        grantId;
  logic                   grantHit;
  logic                   accept;
  logic                   lastChunk;
  logic [CHUNK_WIDTH-1:0] chunkIn;
  logic                   xorOut;

  // (base + k) mod NUM_REQ, k < NUM_REQ
  function automatic logic [ID_W-1:0] wrapAdd(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Round-robin scan starting at rrPtr; first valid requester wins.
  always_comb begin
    grantId  = '0;
    grantHit = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grantHit && bus.reqValid[wrapAdd(rrPtr, k)]) begin
        grantId  = wrapAdd(rrPtr, k);
        grantHit = 1'b1;
      end
    end
  end

  assign accept    = (state == IDLE) && grantHit;
  assign lastChunk = (chunkIdx == LAST_CHUNK);
  assign chunkIn   = dataReg[int'(chunkIdx)*CHUNK_WIDTH +: CHUNK_WIDTH];

  _xor #(.INPUT_WIDTH(CHUNK_WIDTH)) uXor (
    .DigitSupply (DigitSupply),
    .xorIn       (chunkIn),
    .xorOut      (xorOut)
  );

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept)        stateNext = RUN;
      RUN:     if (lastChunk)     stateNext = RESP;
      RESP:    if (bus.respReady) stateNext = IDLE;
      default:                    stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      rrPtr         <= '0;
      chunkIdx      <= '0;
      acc           <= 1'b0;
      dataReg       <= '0;
      idReg         <= '0;
      oddReg        <= 1'b0;
      respIdReg     <= '0;
      respParityReg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dataReg  <= bus.reqData[int'(grantId)*DATA_WIDTH +: DATA_WIDTH];
          idReg    <= grantId;
          oddReg   <= bus.reqOdd[grantId];
          chunkIdx <= '0;
          acc      <= 1'b0;
        end
        RUN: begin
          acc <= acc ^ xorOut;
          if (lastChunk) begin
            // Fold in the final chunk directly; acc has not seen it yet.
            respParityReg <= acc ^ xorOut ^ oddReg;
            respIdReg     <= idReg;
          end else begin
            chunkIdx <= chunkIdx + 1'b1;
          end
        end
        RESP: if (bus.respReady) begin
          // Just-served requester drops to lowest priority.
          rrPtr <= (idReg == LAST_ID) ? '0 : idReg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.reqReady   = accept ? (ONE_HOT0 << grantId) : '0;
  assign bus.respValid  = (state == RESP);
  assign bus.respId     = respIdReg;
  assign bus.respParity = respParityReg;
  assign busy           = (state != IDLE);
endmodule

// File: tb/tb_xor_parity_scheduler.sv
// Directed bench for xor_parity_scheduler: default 4x32/8 instance plus a
// single-chunk (CHUNK_WIDTH=32) instance sharing clock and reset.
module tb_xor_parity_scheduler;
  logic       clock = 1'b0;
  logic       resetN;
  logic [1:0] DigitSupply = 2'b10;
  logic       busyA, busyB;

  always #5 clock = ~clock;

  xor_parity_scheduler_if #(.NUM_REQ(4), .DATA_WIDTH(32)) ifA ();
  xor_parity_scheduler_if #(.NUM_REQ(4), .DATA_WIDTH(32)) ifB ();

  xor_parity_scheduler #(.NUM_REQ(4), .DATA_WIDTH(32), .CHUNK_WIDTH(8)) dutA (
    .clock(clock), .resetN(resetN), .DigitSupply(DigitSupply), .bus(ifA.slave), .busy(busyA)
  );
  xor_parity_scheduler #(.NUM_REQ(4), .DATA_WIDTH(32), .CHUNK_WIDTH(32)) dutB (
    .clock(clock), .resetN(resetN), .DigitSupply(DigitSupply), .bus(ifB.slave), .busy(busyB)
  );

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic setAll(input logic [31:0] d, input logic odd);
    for (int i = 0; i < 4; i++) begin
      ifA.reqData[i*32 +: 32] = d;
      ifA.reqOdd[i]           = odd;
    end
  endtask

  task automatic waitResp(input string tag, input int expId, input logic expPar);
    int lat = 0;
    while (!ifA.respValid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, ".lat"}, lat, 4);
    chk({tag, ".id"},  ifA.respId, expId);
    chk({tag, ".par"}, ifA.respParity, expPar);
    chk({tag, ".busy"}, busyA, 1);
  endtask

  // Offer mask, expect grant g, run the job to completion with respReady=1.
  task automatic job(input string tag, input logic [3:0] mask, input logic [31:0] d,
                     input logic odd, input int g, input logic expPar);
    setAll(d, odd);
    ifA.reqValid = mask;
    #1;
    chk({tag, ".rdy"}, ifA.reqReady, 4'b0001 << g);
    step();
    ifA.reqValid = '0;
    waitResp(tag, g, expPar);
    step();
    chk({tag, ".idle"}, busyA, 0);
  endtask

  task automatic jobB(input string tag, input logic [31:0] d, input logic odd, input logic expPar);
    int lat = 0;
    ifB.reqData[31:0] = d;
    ifB.reqOdd[0]     = odd;
    ifB.reqValid      = 4'b0001;
    #1;
    chk({tag, ".rdy"}, ifB.reqReady, 4'b0001);
    step();
    ifB.reqValid = '0;
    while (!ifB.respValid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, ".lat"}, lat, 1);
    chk({tag, ".par"}, ifB.respParity, expPar);
    chk({tag, ".id"},  ifB.respId, 0);
    step();
    chk({tag, ".idle"}, busyB, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rrData [4];
    logic        rrPar  [4];
    int n, nr, lastC, g;
    logic dropNext;

    resetN        = 1'b0;
    ifA.reqValid  = '0; ifA.reqData = '0; ifA.reqOdd = '0; ifA.respReady = 1'b1;
    ifB.reqValid  = '0; ifB.reqData = '0; ifB.reqOdd = '0; ifB.respReady = 1'b1;
    step();
    step();
    chk("rst.respValid",  ifA.respValid, 0);
    chk("rst.busy",       busyA, 0);
    chk("rst.reqReady",   ifA.reqReady, 0);
    chk("rst.respId",     ifA.respId, 0);
    chk("rst.respParity", ifA.respParity, 0);
    chk("rstB.busy",      busyB, 0);
    resetN = 1'b1;

    // Parity vectors, only req0 valid.
    job("p1", 4'b0001, 32'h0000_0001, 1'b0, 0, 1'b1);
    job("p2", 4'b0001, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    job("p3", 4'b0001, 32'h8000_0003, 1'b1, 0, 1'b0);
    job("p4", 4'b0001, 32'h1234_5678, 1'b0, 0, 1'b1);

    // Reset to bring rrPtr back to 0.
    resetN = 1'b0;
    step();
    resetN = 1'b1;

    // Round robin: all four held valid.
    rrData = '{32'h1, 32'h3, 32'h7, 32'hF};
    rrPar  = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      ifA.reqData[i*32 +: 32] = rrData[i];
      ifA.reqOdd[i]           = 1'b0;
    end
    ifA.reqValid = 4'b1111;
    n = 0; nr = 0; lastC = 0; dropNext = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (ifA.reqReady != 0) begin
        g = 0;
        for (int i = 0; i < 4; i++) if (ifA.reqReady[i]) g = i;
        chk("rr.onehot", $countones(ifA.reqReady), 1);
        if (n < 5) chk("rr.grant", g, n % 4);
        if (n > 0) chk("rr.gap", c - lastC, 6);
        lastC = c;
        n++;
        if (n == 5) dropNext = 1'b1;
      end
      if (ifA.respValid) begin
        chk("rr.id",  ifA.respId, nr % 4);
        chk("rr.par", ifA.respParity, rrPar[ifA.respId]);
        nr++;
      end
      step();
      if (dropNext) begin
        ifA.reqValid = '0;
        dropNext     = 1'b0;
      end
    end
    chk("rr.grants", n, 5);
    chk("rr.resps",  nr, 5);
    step();
    chk("rr.idle", busyA, 0);

    // Fairness after wrap (rrPtr = 1 here).
    job("f3", 4'b1000, 32'h0000_00F0, 1'b0, 3, 1'b0);
    job("f0", 4'b0101, 32'h0000_0001, 1'b0, 0, 1'b1);
    job("f1", 4'b0110, 32'h0000_0003, 1'b0, 1, 1'b0);

    // Backpressure (rrPtr = 2).
    setAll(32'h1234_5678, 1'b0);
    ifA.reqData[63:32] = 32'h0000_0003;
    ifA.reqValid = 4'b0001;
    #1;
    chk("bp.rdy", ifA.reqReady, 4'b0001);
    step();
    ifA.reqValid  = 4'b0010;
    ifA.respReady = 1'b0;
    waitResp("bp", 0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("bp.hold.valid", ifA.respValid, 1);
      chk("bp.hold.id",    ifA.respId, 0);
      chk("bp.hold.par",   ifA.respParity, 1);
      chk("bp.hold.rdy",   ifA.reqReady, 0);
      chk("bp.hold.busy",  busyA, 1);
      step();
    end
    ifA.respReady = 1'b1;
    #1;
    chk("bp.rdyInResp", ifA.reqReady, 0);
    step();
    #1;
    chk("bp.accept", ifA.reqReady, 4'b0010);
    step();
    ifA.reqValid = '0;
    waitResp("bp1", 1, 1'b0);
    step();
    chk("bp.idle", busyA, 0);

    // Reset mid-RUN (rrPtr = 2 before reset).
    setAll(32'h0000_00FF, 1'b0);
    ifA.reqValid = 4'b0001;
    #1;
    chk("mr.rdy", ifA.reqReady, 4'b0001);
    step();
    ifA.reqValid = 4'b1010;
    step();
    step();
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    chk("mr.respValid", ifA.respValid, 0);
    chk("mr.busy",      busyA, 0);
    chk("mr.respId",    ifA.respId, 0);
    ifA.reqData[63:32] = 32'h0000_0001;
    #1;
    chk("mr.rrPtr0", ifA.reqReady, 4'b0010);
    step();
    ifA.reqValid = '0;
    waitResp("mr1", 1, 1'b1);
    step();
    chk("mr.idle", busyA, 0);

    // Single-chunk instance.
    jobB("b1", 32'h0000_0007, 1'b0, 1'b1);
    jobB("b2", 32'h0000_0003, 1'b0, 1'b0);
    jobB("b3", 32'h8000_0001, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule

// File: doc/xor_parity_scheduler.md
Name: xor_parity_scheduler

Overview:
- Time-shares one CHUNK_WIDTH-wide `_xor` reduction datapath between NUM_REQ requesters.
- Each requester submits a DATA_WIDTH word. The block walks the word chunk by chunk through the shared `_xor`, accumulates the per-chunk results and returns the word's parity with the requester ID.
- Sits between client logic and the gate-level XOR chain; it is the only instantiator of that `_xor` in its subsystem.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, bits per request word.
- CHUNK_WIDTH, 8, `INPUT_WIDTH` of the internal `_xor` instance. DATA_WIDTH must be an integer multiple of CHUNK_WIDTH; NCHUNK = DATA_WIDTH/CHUNK_WIDTH, NCHUNK >= 1.

Ports:
- clock  input  1  system clock, rising edge.
- resetN  input  1  synchronous, active-low reset.
- DigitSupply  input  2  supply pair, passed unchanged to the `_xor` instance.
- reqValid  input  NUM_REQ  per-requester request valid.
- reqData  input  NUM_REQ*DATA_WIDTH  flattened words; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- reqOdd  input  NUM_REQ  per-requester odd-parity select; sampled at accept.
- reqReady  output  NUM_REQ  one-hot accept strobe.
- respValid  output  1  result valid.
- respReady  input  1  consumer accepts the result.
- respId  output  clog2(NUM_REQ) (min 1)  ID of the served requester.
- respParity  output  1  XOR of all DATA_WIDTH bits, inverted when the captured reqOdd = 1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (resetN = 0 at a clock edge):
  - state = IDLE, rrPtr = 0, chunkIdx = 0, acc = 0.
  - respValid = 0, respId = 0, respParity = 0, busy = 0, reqReady = 0.
  - Reset anywhere mid-operation discards the job in progress; no response is issued for it.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - If any reqValid is set, grant g = first set bit scanning rrPtr, rrPtr+1, … modulo NUM_REQ.
  - reqReady[g] = 1 combinationally in that cycle only; a handshake occurs when reqValid[g] & reqReady[g].
  - At that edge: capture word[g] into dataReg, g into idReg, reqOdd[g] into oddReg; chunkIdx = 0; acc = 0; go to RUN.
  - If no reqValid is set, stay in IDLE.
- RUN:
  - The `_xor` input is dataReg[chunkIdx*CHUNK_WIDTH +: CHUNK_WIDTH]; each cycle acc <= acc ^ xorOut.
  - If chunkIdx == NCHUNK-1: respParity <= acc ^ xorOut ^ oddReg, respId <= idReg, go to RESP.
  - Otherwise chunkIdx <= chunkIdx + 1.
  - RUN lasts exactly NCHUNK cycles.
- RESP:
  - respValid = 1; respId and respParity held stable.
  - On respValid & respReady: respValid <= 0, rrPtr <= (idReg + 1) mod NUM_REQ, go to IDLE.
- Latency: the accept edge is cycle 0; respValid first rises after edge NCHUNK.
- Throughput: at best one job every NCHUNK + 2 cycles (IDLE, NCHUNK × RUN, RESP with respReady high).
- reqReady is all-zero outside IDLE. Requests arriving during RUN or RESP wait; requesters must hold reqValid and reqData until their reqReady.
- A requester dropping reqValid before its grant is simply skipped; no state is affected.
- If reqValid changes in the same cycle as an IDLE grant, the grant uses the current-cycle values.
- rrPtr wraps from NUM_REQ-1 to 0. The requester just served has lowest priority on the next arbitration.
- NCHUNK = 1: RUN is a single cycle.
- `_xor` is purely combinational: its output is consumed in the cycle its input is presented, with no pipeline register.

Test Plan:
- Parity values, defaults, only req0 valid:
  - reqData0 = 0x00000001, odd = 0 → respParity = 1, respId = 0, respValid rises 4 cycles after accept.
  - 0xFFFFFFFF → 0.
  - 0x80000003, odd = 1 → 0.
- Round robin: all four reqValid held high with distinct data, respReady = 1 → grant order 0, 1, 2, 3, 0. Each reqReady pulses exactly one cycle; jobs are spaced 6 cycles apart.
- Fairness after wrap: serve req3, then raise req0 and req2 together → req0 is granted first (rrPtr = 0). Next, with req1 and req2 both valid → req1 is granted before req2.
- Backpressure: respReady held low for 5 cycles in RESP → respValid, respId and respParity stay stable. reqReady stays 0 and busy stays 1 although req1 is valid; req1 is accepted in the cycle after respReady rises.
- Reset mid-RUN: assert resetN = 0 for one edge at chunkIdx = 2 → next cycle state is IDLE, respValid = 0, busy = 0, rrPtr = 0. The job is never reported; the pending req1 is then served normally.
- CHUNK_WIDTH = 32 (NCHUNK = 1): 0x00000007 → respParity = 1, respValid rises 1 cycle after accept.
